bram_loader: RTL and testbench
==============================

BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 10, number of memory words.
REQ-002 SHALL have parameter WIDTH, default 4, bits per word.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load sequence.
REQ-006 SHALL have port abort  input  1  terminates an in-progress load.
REQ-007 SHALL have port in_valid  input  1  in_data holds a word to write.
REQ-008 SHALL have port in_data  input  WIDTH  write word.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port rd_addr  input  4  read address.
REQ-011 SHALL have port rd_data  output  WIDTH  registered read data.
REQ-012 SHALL have port busy  output  1  high while in LOAD.
REQ-013 SHALL have port done  output  1  one-cycle pulse when all DEPTH words are written.
REQ-014 SHALL have port count  output  4  number of words written in the current or last load.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DONE; reset state IDLE.
REQ-016 IDLE: in_ready=0; start=1 -> LOAD next cycle, wr_ptr and count cleared to 0.
REQ-017 LOAD: in_ready=1, busy=1; a transfer occurs when in_valid&&in_ready at a rising edge.
REQ-018 On a transfer: mem[wr_ptr]<=in_data, wr_ptr and count increment by 1.
REQ-019 A transfer at wr_ptr==DEPTH-1 -> DONE; wr_ptr does not wrap past DEPTH-1.
REQ-020 DONE: done=1 for exactly one cycle, in_ready=0, then -> IDLE unconditionally.
REQ-021 start while in LOAD or DONE SHALL be ignored.
REQ-022 abort in LOAD -> IDLE next cycle; a transfer coinciding with abort is discarded (no write, count unchanged); done not asserted.
REQ-023 abort outside LOAD SHALL have no effect; abort and start together in IDLE: start wins.
REQ-024 in_valid while in_ready=0 SHALL cause no write and no state change.
REQ-025 Read port: rd_data<=mem[rd_addr] at each rising edge, latency 1 cycle, independent of FSM state.
REQ-026 rd_addr>=DEPTH SHALL return rd_data=0 on the next cycle.
REQ-027 Read and write of the same address in the same cycle SHALL return the old (pre-write) word.
REQ-028 count SHALL hold its value in IDLE and DONE until the next start.
REQ-029 Memory contents SHALL persist across loads; words not rewritten keep prior values.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, wr_ptr=0, count=0, busy=0, done=0, in_ready=0, rd_data=0.
REQ-031 Memory array SHALL not be reset (block-RAM inference); contents undefined until written.
REQ-032 Reset asserted mid-LOAD SHALL abandon the load with no done pulse; reset release is synchronous-safe (first transition no earlier than first rising edge after release).

Structure
REQ-033 State encoding (IDLE/LOAD/DONE) and default DEPTH/WIDTH constants SHALL live in a shared package.
REQ-034 One sub-module bram_sdp (simple dual-port: one write port, one registered read port, read-old-data) SHALL hold the memory; FSM and counters stay in bram_loader.

Verification
REQ-035 Full load: start, then 10 back-to-back transfers of 0xA,0x6,0xC,0x3,0x9,0x5,0xF,0x0,0xB,0x7 -> done pulse the cycle after the 10th transfer, count=10; readback addr 0..9 returns the same values, 1-cycle latency.
REQ-036 Throttled: in_valid toggled every other cycle -> only valid cycles write; done after 10th accepted word; count progresses 1..10.
REQ-037 Abort: start, 4 transfers (0x1..0x4), abort together with 5th transfer 0x5 -> IDLE, count=4, addr4 keeps prior value, no done.
REQ-038 Out-of-range and collision: rd_addr=12 -> rd_data=0; read addr 2 while writing 0xE to addr 2 -> old value, next read 0xE.
REQ-039 Reset mid-load: rst_n low after 6 transfers -> outputs zero immediately (asynchronous), state IDLE, no done; new start reloads correctly.
REQ-040 Ignored inputs: start during LOAD and in_valid in IDLE -> no restart, no write, count unchanged.

Source files
------------

// File: rtl/bram_loader_pkg.sv
// bram_loader_pkg: shared state encoding and default sizing for the BRAM loader
package bram_loader_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;
   localparam int DEPTH_DEF = 10;
   localparam int WIDTH_DEF = 4;
   localparam int AW        = 4;
endpackage

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port RAM, one write port, one registered read port returning old data on collision
module bram_sdp
   import bram_loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_d, rd_data_q;
   // addresses beyond the array read back as zero
   always_comb rd_data_d = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
   // storage is left unreset so it maps onto block RAM
   always_ff @(posedge clk)
      if (we && ({1'b0, wr_addr} < DEPTH_W)) mem[wr_addr] <= wr_data;
   // read register samples pre-write contents, giving read-old-data on collision
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   assign rd_data = rd_data_q;
endmodule

// File: rtl/bram_loader.sv
// bram_loader: streams DEPTH words into a BRAM under a start/abort handshake, with an independent read port
module bram_loader
   import bram_loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic [3:0]       rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic [3:0]       count
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, count_q, count_d;
   logic          we;
   // next-state: start opens a load, abort discards the current beat, the last beat finishes
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      we       = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d  = LOAD;
            wr_ptr_d = '0;
            count_d  = '0;
         end
         LOAD: if (abort) state_d = IDLE;
         else if (in_valid) begin
            we       = 1'b1;
            count_d  = count_q + 4'd1;
            state_d  = (wr_ptr_q == LAST) ? DONE : LOAD;
            wr_ptr_d = (wr_ptr_q == LAST) ? wr_ptr_q : wr_ptr_q + 4'd1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // control registers, cleared asynchronously so a reset mid-load drops the load
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   assign busy     = (state_q == LOAD);
   assign in_ready = (state_q == LOAD);
   assign done     = (state_q == DONE);
   assign count    = count_q;
   bram_sdp #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: table vectors, directed corner sequences and random traffic against a word-list model
module tb_bram_loader;
   localparam int DEPTH = 10;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [3:0] in_data = '0, rd_addr = '0;
   logic       in_ready, busy, done;
   logic [3:0] rd_data, count;
   bram_loader #(.DEPTH(DEPTH), .WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .count(count)
   );
   always #5 clk = ~clk;
   int n_pass = 0, n_total = 0;
   // reference: words stored so far, whether a load is open, and a pending done pulse
   logic [3:0] m_mem [DEPTH];
   bit         m_known [DEPTH];
   bit         m_load, m_done, m_rd_known;
   int         m_cnt;
   logic [3:0] m_rd;
   typedef struct {
      bit s, a, v;
      logic [3:0] d, ra;
      bit eb, ed;
      logic [3:0] ec;
      bit rk;
      logic [3:0] er;
   } vec_t;
   vec_t tbl [21];
   logic [3:0] vals [10] = '{4'hA, 4'h6, 4'hC, 4'h3, 4'h9, 4'h5, 4'hF, 4'h0, 4'hB, 4'h7};
   task automatic chk(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask
   task automatic model_edge();
      logic [3:0] nrd;
      bit nk;
      if (!rst_n) return;
      nk  = 1'b1;
      nrd = '0;
      if (rd_addr < DEPTH) begin
         nk  = m_known[rd_addr];
         nrd = m_mem[rd_addr];
      end
      if (m_done) m_done = 0;
      else if (m_load) begin
         if (abort) m_load = 0;
         else if (in_valid) begin
            m_mem[m_cnt]   = in_data;
            m_known[m_cnt] = 1;
            m_cnt++;
            if (m_cnt == DEPTH) begin
               m_load = 0;
               m_done = 1;
            end
         end
      end else if (start) begin
         m_load = 1;
         m_cnt  = 0;
      end
      m_rd       = nrd;
      m_rd_known = nk;
   endtask
   task automatic check_model();
      chk("busy", busy, int'(m_load));
      chk("in_ready", in_ready, int'(m_load));
      chk("done", done, int'(m_done));
      chk("count", count, m_cnt);
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
   endtask
   task automatic cyc(bit s, bit a, bit v, logic [3:0] d, logic [3:0] ra);
      start = s; abort = a; in_valid = v; in_data = d; rd_addr = ra;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask
   task automatic do_reset();
      start = 0; abort = 0; in_valid = 0;
      rst_n = 0;
      #1;
      m_load = 0; m_done = 0; m_cnt = 0; m_rd = '0; m_rd_known = 1;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_rd_data", rd_data, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1;
   endtask
   initial begin
      logic [3:0] exp4;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
      tbl[0] = '{s:1, a:0, v:0, d:0, ra:0, eb:1, ed:0, ec:0, rk:0, er:0};
      for (int k = 1; k <= 10; k++)
         tbl[k] = '{s:0, a:0, v:1, d:vals[k-1], ra:0, eb:(k < 10), ed:(k == 10), ec:4'(k), rk:0, er:0};
      for (int i = 0; i < 10; i++)
         tbl[11+i] = '{s:0, a:0, v:0, d:0, ra:4'(i), eb:0, ed:0, ec:4'd10, rk:1, er:vals[i]};
      #1;
      do_reset();
      // full load from the table, then readback with one-cycle latency
      for (int i = 0; i < 21; i++) begin
         cyc(tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].d, tbl[i].ra);
         chk("tbl_busy", busy, int'(tbl[i].eb));
         chk("tbl_done", done, int'(tbl[i].ed));
         chk("tbl_count", count, tbl[i].ec);
         if (tbl[i].rk) chk("tbl_rd", rd_data, tbl[i].er);
      end
      // throttled load: only every other cycle carries a word
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 19; k++) cyc(0, 0, (k % 2) == 0, 4'($urandom_range(0, 15)), 0);
      chk("thr_done", done, 1);
      chk("thr_count", count, 10);
      cyc(0, 0, 0, 0, 0);
      chk("thr_done_clear", done, 0);
      // abort together with the fifth word
      exp4 = m_mem[4];
      cyc(1, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) cyc(0, 0, 1, 4'(k), 0);
      cyc(0, 1, 1, 4'h5, 4);
      chk("abort_busy", busy, 0);
      chk("abort_count", count, 4);
      chk("abort_done", done, 0);
      cyc(0, 0, 0, 0, 4);
      chk("abort_addr4", rd_data, exp4);
      chk("abort_done2", done, 0);
      // out-of-range read and read/write collision on address 2
      cyc(0, 0, 0, 0, 12);
      chk("oor_rd", rd_data, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 4'h1, 0);
      cyc(0, 0, 1, 4'h2, 0);
      cyc(0, 0, 1, 4'hE, 2);
      chk("coll_old", rd_data, 4'h3);
      cyc(0, 1, 0, 0, 2);
      chk("coll_new", rd_data, 4'hE);
      // reset in the middle of a load, then a clean reload
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) cyc(0, 0, 1, 4'($urandom_range(0, 15)), 0);
      chk("pre_rst_count", count, 6);
      do_reset();
      cyc(0, 0, 0, 0, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) cyc(0, 0, 1, 4'($urandom_range(0, 15)), 0);
      chk("reload_done", done, 1);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 4'(i));
      // ignored inputs: write in IDLE, abort in IDLE, start in LOAD, start+abort in IDLE
      cyc(0, 0, 1, 4'hF, 0);
      chk("idle_valid_count", count, 10);
      cyc(0, 1, 0, 0, 0);
      chk("idle_abort_busy", busy, 0);
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, 4'(k), 0);
      cyc(1, 0, 1, 4'h8, 0);
      chk("load_start_count", count, 4);
      chk("load_start_busy", busy, 1);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("start_abort_busy", busy, 1);
      chk("start_abort_count", count, 0);
      cyc(0, 1, 0, 0, 0);
      // random traffic against the model
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
